rob_commit: RTL and testbench

- Reorder buffer for the out-of-order RISC-V core. It allocates a dependency tag per decoded instruction, collects results from the common writeback bus, and retires in program order.
- It is the sender of the register-file commit interface: rob_valid/rob_rd/rob_value/rob_dependency, need_flush, and rob_new_dependency.
- It answers operand-readiness queries from the decoder and triggers a pipeline flush on a redirecting commit.

---
 rtl/rob_commit.sv | 179 +++++++++++++++++
 tb/tb_rob_commit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// In-order retirement reorder buffer: tag allocation, writeback capture, operand queries, commit and flush.
// Optional ROB_COMMIT_CNT_EN adds a free-running retired-instruction counter on commit_cnt_out.
module rob_commit #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int REG_NUM_WIDTH  = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
  input  logic                      dec_is_store,
  output logic [ROB_SIZE_WIDTH:0]   rob_new_dependency,
  output logic                      rob_full,
  input  logic                      wb_valid,
  input  logic [ROB_SIZE_WIDTH:0]   wb_tag,
  input  logic [31:0]               wb_value,
  input  logic                      wb_redirect,
  input  logic [31:0]               wb_redirect_pc,
  input  logic [ROB_SIZE_WIDTH:0]   query1_tag,
  input  logic [ROB_SIZE_WIDTH:0]   query2_tag,
  output logic                      query1_ready,
  output logic                      query2_ready,
  output logic [31:0]               query1_value,
  output logic [31:0]               query2_value,
  output logic                      rob_valid,
  output logic [REG_NUM_WIDTH-1:0]  rob_rd,
  output logic [31:0]               rob_value,
  output logic [ROB_SIZE_WIDTH:0]   rob_dependency,
  output logic                      store_commit_out,
  output logic                      need_flush_out,
  output logic [31:0]               flush_pc_out,
  output logic [31:0]               commit_cnt_out
);

  localparam int N  = 1 << ROB_SIZE_WIDTH;
  localparam int TW = ROB_SIZE_WIDTH + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;
  logic [ROB_SIZE_WIDTH-1:0] head_q, tail_q, wb_idx;
  logic [TW-1:0]             count_q;
  logic [N-1:0]              e_valid, e_ready, e_store, e_redirect;
  logic [REG_NUM_WIDTH-1:0]  e_rd    [N];
  logic [31:0]               e_value [N];
  logic [31:0]               e_pc    [N];
  logic [31:0]               flush_pc_q;
  logic                      run, do_alloc, do_commit, do_redirect, wb_hit;
  logic [TW-1:0]             q_tag [2];
  logic                      q_rdy [2];
  logic [31:0]               q_val [2];

  assign rob_full           = (state_q == FLUSH) || (count_q == TW'(N));
  assign rob_new_dependency = {1'b0, tail_q};
  assign wb_idx             = wb_tag[ROB_SIZE_WIDTH-1:0];

  assign run         = rdy_in && (state_q == RUN);
  assign do_alloc    = run && dec_valid && !rob_full;
  assign do_commit   = run && (count_q != '0) && e_valid[head_q] && e_ready[head_q];
  assign do_redirect = do_commit && e_redirect[head_q];
  assign wb_hit      = run && wb_valid && (wb_tag != '1) && e_valid[wb_idx] && !e_ready[wb_idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (do_redirect) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign q_tag[0]     = query1_tag;
  assign q_tag[1]     = query2_tag;
  assign query1_ready = q_rdy[0];
  assign query2_ready = q_rdy[1];
  assign query1_value = q_val[0];
  assign query2_value = q_val[1];

  // Priority: no-dependency tag, stored result, then same-cycle writeback bypass.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      q_rdy[i] = 1'b0;
      q_val[i] = '0;
      if (q_tag[i] == '1) begin
        q_rdy[i] = 1'b1;
      end else if (e_valid[q_tag[i][ROB_SIZE_WIDTH-1:0]] && e_ready[q_tag[i][ROB_SIZE_WIDTH-1:0]]) begin
        q_rdy[i] = 1'b1;
        q_val[i] = e_value[q_tag[i][ROB_SIZE_WIDTH-1:0]];
      end else if (wb_valid && (wb_tag == q_tag[i])) begin
        q_rdy[i] = 1'b1;
        q_val[i] = wb_value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= RUN;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      e_valid          <= '0;
      e_ready          <= '0;
      flush_pc_q       <= '0;
      rob_valid        <= 1'b0;
      rob_rd           <= '0;
      rob_value        <= '0;
      rob_dependency   <= '1;
      store_commit_out <= 1'b0;
      need_flush_out   <= 1'b0;
      flush_pc_out     <= '0;
    end else begin
      rob_valid        <= 1'b0;
      store_commit_out <= 1'b0;
      need_flush_out   <= 1'b0;
      if (rdy_in) begin
        state_q <= state_d;
        if (state_q == FLUSH) begin
          need_flush_out <= 1'b1;
          flush_pc_out   <= flush_pc_q;
          e_valid        <= '0;
          e_ready        <= '0;
          head_q         <= '0;
          tail_q         <= '0;
          count_q        <= '0;
        end else begin
          if (wb_hit) e_ready[wb_idx] <= 1'b1;
          if (do_alloc) begin
            e_valid[tail_q] <= 1'b1;
            e_ready[tail_q] <= 1'b0;
            tail_q          <= tail_q + 1'b1;
          end
          if (do_commit) begin
            rob_valid        <= 1'b1;
            rob_rd           <= e_rd[head_q];
            rob_value        <= e_value[head_q];
            rob_dependency   <= {1'b0, head_q};
            store_commit_out <= e_store[head_q];
            e_valid[head_q]  <= 1'b0;
            head_q           <= head_q + 1'b1;
            if (do_redirect) flush_pc_q <= e_pc[head_q];
          end
          case ({do_alloc, do_commit})
            2'b10:   count_q <= count_q + TW'(1);
            2'b01:   count_q <= count_q - TW'(1);
            default: count_q <= count_q;
          endcase
        end
      end
    end
  end

  // Payload fields are only read behind e_valid/e_ready, so they need no reset.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      e_rd[tail_q]       <= dec_rd;
      e_store[tail_q]    <= dec_is_store;
      e_redirect[tail_q] <= 1'b0;
    end
    if (wb_hit) begin
      e_value[wb_idx]    <= wb_value;
      e_redirect[wb_idx] <= wb_redirect;
      e_pc[wb_idx]       <= wb_redirect_pc;
    end
  end

`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else if (do_commit) cnt_q <= cnt_q + 32'd1;
  end
  assign commit_cnt_out = cnt_q;
`else
  assign commit_cnt_out = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected commits/flushes, a negedge monitor checks them.
module tb_rob_commit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rd = '0;
  logic        dec_is_store = 1'b0;
  logic [3:0]  rob_new_dependency;
  logic        rob_full;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        wb_redirect = 1'b0;
  logic [31:0] wb_redirect_pc = '0;
  logic [3:0]  query1_tag = '1, query2_tag = '1;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_value, query2_value;
  logic        rob_valid;
  logic [4:0]  rob_rd;
  logic [31:0] rob_value;
  logic [3:0]  rob_dependency;
  logic        store_commit_out, need_flush_out;
  logic [31:0] flush_pc_out, commit_cnt_out;

  rob_commit #(.ROB_SIZE_WIDTH(3), .REG_NUM_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_is_store(dec_is_store),
    .rob_new_dependency(rob_new_dependency), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_redirect(wb_redirect), .wb_redirect_pc(wb_redirect_pc),
    .query1_tag(query1_tag), .query2_tag(query2_tag),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .rob_valid(rob_valid), .rob_rd(rob_rd), .rob_value(rob_value),
    .rob_dependency(rob_dependency), .store_commit_out(store_commit_out),
    .need_flush_out(need_flush_out), .flush_pc_out(flush_pc_out),
    .commit_cnt_out(commit_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  dep;
    logic        st;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fq[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  logic        prev_valid = 1'b0;

`ifdef ROB_COMMIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (rob_valid) begin
          exp_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_commit", 32'(rob_dependency), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("commit_rd", 32'(rob_rd), 32'(e.rd));
            check("commit_value", rob_value, e.val);
            check("commit_dep", 32'(rob_dependency), 32'(e.dep));
            check("commit_store", 32'(store_commit_out), 32'(e.st));
          end
          check("commit_cnt_track", commit_cnt_out, cnt_exp(exp_cnt));
        end else if (store_commit_out) begin
          check("stray_store_pulse", 32'(store_commit_out), 32'd0);
        end
        if (need_flush_out) begin
          if (fq.size() == 0) check("unexpected_flush", flush_pc_out, 32'hFFFF_FFFF);
          else check("flush_pc", flush_pc_out, fq.pop_front());
          check("flush_after_commit", 32'(prev_valid), 32'd1);
        end
        prev_valid = rob_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    exp_cnt = 0;
    sb.delete();
    fq.delete();
    #1;
    check("rst_valid", 32'(rob_valid), 32'd0);
    check("rst_store", 32'(store_commit_out), 32'd0);
    check("rst_flush", 32'(need_flush_out), 32'd0);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_newdep", 32'(rob_new_dependency), 32'd0);
    check("rst_dep", 32'(rob_dependency), 32'hF);
    check("rst_cnt", commit_cnt_out, 32'd0);
    rst_in = 1'b1;
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st);
    dec_valid = 1'b1; dec_rd = rd; dec_is_store = st;
    tick();
    dec_valid = 1'b0; dec_is_store = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic redir, input logic [31:0] pc);
    wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_redirect = redir; wb_redirect_pc = pc;
    tick();
    wb_valid = 1'b0; wb_redirect = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || fq.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    tick();
    check(name, 32'(sb.size() + fq.size()), 32'd0);
    sb.delete();
    fq.delete();
  endtask

  initial begin
    logic [31:0] vals [8];
    @(posedge clk_in); #1;
    do_reset();

    // Redirecting commit followed by a flush
    alloc(5'd1, 1'b0); alloc(5'd2, 1'b0); alloc(5'd3, 1'b0);
    sb.push_back('{rd: 5'd1, val: 32'h104, dep: 4'd0, st: 1'b0});
    fq.push_back(32'h200);
    wb(4'd0, 32'h104, 1'b1, 32'h200);
    tick();
    check("flush_state_full", 32'(rob_full), 32'd1);
    wb_valid = 1'b1; wb_tag = 4'd1; wb_value = 32'h99;
    dec_valid = 1'b1; dec_rd = 5'd9;
    tick();
    wb_valid = 1'b0; dec_valid = 1'b0;
    check("post_flush_newdep", 32'(rob_new_dependency), 32'd0);
    check("post_flush_full", 32'(rob_full), 32'd0);
    query1_tag = 4'd1; #1;
    check("post_flush_q1_ready", 32'(query1_ready), 32'd0);
    query1_tag = '1;
    drain("flush_drain");
    repeat (3) tick();

    // Out-of-order writeback, in-order commit
    alloc(5'd5, 1'b0); alloc(5'd6, 1'b0); alloc(5'd7, 1'b0);
    check("newdep_after3", 32'(rob_new_dependency), 32'd3);
    sb.push_back('{rd: 5'd5, val: 32'h10, dep: 4'd0, st: 1'b0});
    sb.push_back('{rd: 5'd6, val: 32'h20, dep: 4'd1, st: 1'b0});
    sb.push_back('{rd: 5'd7, val: 32'h30, dep: 4'd2, st: 1'b0});
    wb(4'd2, 32'h30, 1'b0, 32'h0);
    wb(4'd0, 32'h10, 1'b0, 32'h0);
    wb(4'd1, 32'h20, 1'b0, 32'h0);
    drain("order_drain");

    alloc(5'd4, 1'b0);
    sb.push_back('{rd: 5'd4, val: 32'h40, dep: 4'd3, st: 1'b0});
    wb(4'd3, 32'h40, 1'b0, 32'h0);
    drain("fifth_drain");
    check("commit_cnt_5", commit_cnt_out, cnt_exp(5));

    // Reset mid-stream during a commit pulse
    alloc(5'd10, 1'b0); alloc(5'd11, 1'b0); alloc(5'd12, 1'b0); alloc(5'd13, 1'b0);
    wb(4'd4, 32'h77, 1'b0, 32'h0);
    tick();
    check("pre_reset_pulse", 32'(rob_valid), 32'd1);
    do_reset();
    alloc(5'd20, 1'b0);
    sb.push_back('{rd: 5'd20, val: 32'h2020, dep: 4'd0, st: 1'b0});
    wb(4'd0, 32'h2020, 1'b0, 32'h0);
    drain("post_reset_drain");
    check("commit_cnt_1", commit_cnt_out, cnt_exp(1));

    // Fill to capacity, then drain with a bypassed query on tag 3
    do_reset();
    dec_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dec_rd = 5'(8 + i); dec_is_store = (i == 2);
      tick();
    end
    dec_valid = 1'b0; dec_is_store = 1'b0;
    check("full_set", 32'(rob_full), 32'd1);
    check("full_newdep", 32'(rob_new_dependency), 32'd0);
    alloc(5'd31, 1'b0);
    check("ninth_ignored_newdep", 32'(rob_new_dependency), 32'd0);
    check("ninth_full", 32'(rob_full), 32'd1);
    sb.push_back('{rd: 5'd8, val: 32'h55, dep: 4'd0, st: 1'b0});
    wb(4'd0, 32'h55, 1'b0, 32'h0);
    check("full_before_commit", 32'(rob_full), 32'd1);
    tick();
    check("full_after_commit", 32'(rob_full), 32'd0);
    for (int i = 1; i < 8; i++) vals[i] = (i == 3) ? 32'hABCD : 32'(i * 32'h111);
    for (int i = 1; i < 8; i++) begin
      sb.push_back('{rd: 5'(8 + i), val: vals[i], dep: 4'(i), st: (i == 2)});
      if (i == 3) begin
        query1_tag = 4'd3; query2_tag = '1; #1;
        check("q1_pending", 32'(query1_ready), 32'd0);
        wb_valid = 1'b1; wb_tag = 4'd3; wb_value = 32'hABCD; #1;
        check("q1_bypass_ready", 32'(query1_ready), 32'd1);
        check("q1_bypass_value", query1_value, 32'hABCD);
        check("q2_nodep_ready", 32'(query2_ready), 32'd1);
        check("q2_nodep_value", query2_value, 32'd0);
        wb(4'd3, 32'hABCD, 1'b0, 32'h0);
        check("q1_entry_ready", 32'(query1_ready), 32'd1);
        check("q1_entry_value", query1_value, 32'hABCD);
        query1_tag = '1;
      end else begin
        wb(4'(i), vals[i], 1'b0, 32'h0);
      end
    end
    drain("full_drain");
    check("final_full", 32'(rob_full), 32'd0);
    check("final_newdep", 32'(rob_new_dependency), 32'd0);
    check("final_cnt", commit_cnt_out, cnt_exp(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
